// File: rtl/vocoder_pkg.sv
// Shared vocoder definitions: fetch FSM state type and default bank geometry.
// Used by the carrier fetch and by the envelope/carrier mixer.
package vocoder_pkg;
    localparam int N_BANDS       = 15;
    localparam int SAMPLE_W      = 16;
    localparam int CARRIER_DEPTH = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_e;
endpackage

// File: rtl/carrier_fetch_rdpipe.sv
// Read-tracking pipeline: carries (valid, band index) alongside each BRAM read
// so the tail lines up with the returned data word.
module carrier_fetch_rdpipe
    import vocoder_pkg::*;
#(
    parameter int LAT = 2,
    parameter int IW  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld_i,
    input  logic [IW-1:0] in_idx_i,
    output logic          out_vld_o,
    output logic [IW-1:0] out_idx_o
);
    logic [LAT-1:0]         vld_q;
    logic [LAT-1:0][IW-1:0] idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q[0] <= in_vld_i;
            idx_q[0] <= in_idx_i;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign out_vld_o = vld_q[LAT-1];
    assign out_idx_o = idx_q[LAT-1];
endmodule

// File: rtl/carrier_bank_fetch.sv
// Per sample tick, reads one word from each of N carrier tables and presents the bank.
// Optional CARRIER_FETCH_OVR_COUNT_EN adds a saturating dropped-tick counter (ovr_count).
module carrier_bank_fetch
    import vocoder_pkg::*;
#(
    parameter int N      = N_BANDS,
    parameter int WIDTH  = SAMPLE_W,
    parameter int DEPTH  = CARRIER_DEPTH,
    parameter int RD_LAT = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                sample_tick,
    output logic                                bram_en,
    output logic [$clog2(N*DEPTH)-1:0]          bram_addr,
    input  logic signed [WIDTH-1:0]             bram_dout,
    output logic [N-1:0][WIDTH-1:0]             carrier_out,
    output logic                                carrier_valid,
    output logic                                busy,
    output logic                                overrun
`ifdef CARRIER_FETCH_OVR_COUNT_EN
    ,
    output logic [7:0]                          ovr_count
`endif
);
    localparam int AW = $clog2(N*DEPTH);
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_state_e           state_q, state_d;
    logic [BW-1:0]          band_q, band_d;
    logic [BW-1:0]          iss_band_q, iss_band_d;
    logic [DW-1:0]          phase_q, phase_d;
    logic                   bram_en_q, bram_en_d;
    logic [AW-1:0]          bram_addr_q, bram_addr_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic [N-1:0][WIDTH-1:0] carrier_q;
    logic                   cap_vld;
    logic [BW-1:0]          cap_idx;
    logic                   tick_drop;

    // A tick while busy (DONE cycle included) is dropped and only flagged.
    assign tick_drop = sample_tick & busy_q;

    carrier_fetch_rdpipe #(.LAT(RD_LAT), .IW(BW)) u_rdpipe (
        .clk       (clk),
        .rst       (rst),
        .in_vld_i  (bram_en_q),
        .in_idx_i  (iss_band_q),
        .out_vld_o (cap_vld),
        .out_idx_o (cap_idx)
    );

    always_comb begin
        state_d     = state_q;
        band_d      = band_q;
        iss_band_d  = iss_band_q;
        phase_d     = phase_q;
        bram_en_d   = 1'b0;
        bram_addr_d = bram_addr_q;
        busy_d      = busy_q;
        overrun_d   = overrun_q | tick_drop;
        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    state_d = ISSUE;
                    band_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            ISSUE: begin
                // DEPTH is a power of two, so band*DEPTH + phase is a concatenation.
                bram_en_d   = 1'b1;
                bram_addr_d = AW'({band_q, phase_q});
                iss_band_d  = band_q;
                band_d      = band_q + 1'b1;
                if (band_q == BW'(N-1)) state_d = DRAIN;
            end
            DRAIN: begin
                if (cap_vld && cap_idx == BW'(N-1)) state_d = DONE;
            end
            DONE: begin
                phase_d = phase_q + 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            band_q      <= '0;
            iss_band_q  <= '0;
            phase_q     <= '0;
            bram_en_q   <= 1'b0;
            bram_addr_q <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            band_q      <= band_d;
            iss_band_q  <= iss_band_d;
            phase_q     <= phase_d;
            bram_en_q   <= bram_en_d;
            bram_addr_q <= bram_addr_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carrier_q <= '0;
        end else if (cap_vld) begin
            carrier_q[cap_idx] <= bram_dout;
        end
    end

`ifdef CARRIER_FETCH_OVR_COUNT_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;

    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (tick_drop && ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovr_cnt_q <= '0;
        else     ovr_cnt_q <= ovr_cnt_d;
    end

    assign ovr_count = ovr_cnt_q;
`endif

    assign bram_en       = bram_en_q;
    assign bram_addr     = bram_addr_q;
    assign carrier_out   = carrier_q;
    assign carrier_valid = (state_q == DONE);
    assign busy          = busy_q;
    assign overrun       = overrun_q;
endmodule

// File: tb/tb_carrier_bank_fetch.sv
// Bench for carrier_bank_fetch: BRAM returns data = address; a tick-level model
// predicts accepted fetches, addresses, bank contents, busy time and overrun.
module tb_carrier_bank_fetch;
    localparam int N      = 15;
    localparam int WIDTH  = 16;
    localparam int DEPTH  = 8;
    localparam int RD_LAT = 2;
    localparam int AW     = $clog2(N*DEPTH);
    localparam int LAT    = N + RD_LAT + 2;
    localparam int BANKW  = N * WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sample_tick = 1'b0;
    logic bram_en;
    logic [AW-1:0] bram_addr;
    logic signed [WIDTH-1:0] bram_dout;
    logic [N-1:0][WIDTH-1:0] carrier_out;
    logic carrier_valid, busy, overrun;
`ifdef CARRIER_FETCH_OVR_COUNT_EN
    logic [7:0] ovr_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    carrier_bank_fetch #(.N(N), .WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_tick   (sample_tick),
        .bram_en       (bram_en),
        .bram_addr     (bram_addr),
        .bram_dout     (bram_dout),
        .carrier_out   (carrier_out),
        .carrier_valid (carrier_valid),
        .busy          (busy),
        .overrun       (overrun)
`ifdef CARRIER_FETCH_OVR_COUNT_EN
        ,
        .ovr_count     (ovr_count)
`endif
    );

    // Two-cycle BRAM whose content equals its address.
    logic [AW-1:0] bram_a1;
    always @(posedge clk) begin
        bram_a1   <= bram_addr;
        bram_dout <= WIDTH'(bram_a1);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int              o_vld_cyc[$];
    logic [BANKW-1:0] o_bank[$];
    logic [63:0]     o_addr[$];
    int              o_busy = 0;

    always @(negedge clk) begin
        if (carrier_valid) begin
            o_vld_cyc.push_back(cyc);
            o_bank.push_back(carrier_out);
        end
        if (bram_en) o_addr.push_back({32'(cyc), 32'(bram_addr)});
        if (busy) o_busy++;
    end

    // Reference model at tick granularity.
    int              m_busy_end, m_ph, m_drops, m_busy_cyc;
    bit              m_ovr;
    int              e_vld_cyc[$];
    logic [BANKW-1:0] e_bank[$];
    logic [63:0]     e_addr[$];

    function automatic void model_reset();
        m_busy_end = -1000;
        m_ph = 0; m_drops = 0; m_busy_cyc = 0; m_ovr = 0;
        e_vld_cyc.delete(); e_bank.delete(); e_addr.delete();
        o_vld_cyc.delete(); o_bank.delete(); o_addr.delete();
        o_busy = 0;
    endfunction

    function automatic void model_tick(input int tc);
        logic [BANKW-1:0] b;
        if (tc <= m_busy_end) begin
            m_ovr = 1;
            m_drops++;
        end else begin
            m_busy_end = tc + LAT;
            m_busy_cyc += LAT;
            for (int k = 0; k < N; k++) begin
                b[k*WIDTH +: WIDTH] = WIDTH'(k*DEPTH + m_ph);
                e_addr.push_back({32'(tc + 2 + k), 32'(k*DEPTH + m_ph)});
            end
            e_vld_cyc.push_back(tc + LAT);
            e_bank.push_back(b);
            m_ph = (m_ph + 1) % DEPTH;
        end
    endfunction

    task automatic check(input string tag, input logic [BANKW-1:0] obs, input logic [BANKW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fire_tick();
        model_tick(cyc);
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
    endtask

    task automatic cmp_fetches(input string tag);
        int nv, na;
        check({tag, "_nvld"}, o_vld_cyc.size(), e_vld_cyc.size());
        nv = (o_vld_cyc.size() < e_vld_cyc.size()) ? o_vld_cyc.size() : e_vld_cyc.size();
        for (int i = 0; i < nv; i++) begin
            check({tag, "_vldcyc"}, o_vld_cyc[i], e_vld_cyc[i]);
            check({tag, "_bank"}, o_bank[i], e_bank[i]);
        end
        check({tag, "_naddr"}, o_addr.size(), e_addr.size());
        na = (o_addr.size() < e_addr.size()) ? o_addr.size() : e_addr.size();
        for (int i = 0; i < na; i++) check({tag, "_addr"}, o_addr[i], e_addr[i]);
        check({tag, "_busycyc"}, o_busy, m_busy_cyc);
        check({tag, "_busy_idle"}, busy, 1'b0);
        check({tag, "_overrun"}, overrun, m_ovr);
`ifdef CARRIER_FETCH_OVR_COUNT_EN
        check({tag, "_ovrcnt"}, ovr_count, (m_drops > 255) ? 255 : m_drops);
`endif
        e_vld_cyc.delete(); e_bank.delete(); e_addr.delete();
        o_vld_cyc.delete(); o_bank.delete(); o_addr.delete();
        o_busy = 0; m_busy_cyc = 0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        step(n);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step(3);
        check("rst_bram_en", bram_en, 1'b0);
        check("rst_bram_addr", bram_addr, '0);
        check("rst_valid", carrier_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_carrier", carrier_out, '0);
`ifdef CARRIER_FETCH_OVR_COUNT_EN
        check("rst_ovrcnt", ovr_count, '0);
`endif
        rst = 1'b0;
        model_reset();
        step(2);

        // Single tick
        fire_tick();
        step(LAT + 6);
        cmp_fetches("single");

        // Nine spaced ticks, phase wrap
        do_reset(2);
        for (int t = 0; t < 9; t++) begin
            fire_tick();
            step(39 + $urandom_range(0, 4));
        end
        for (int i = 0; i < o_bank.size() && i < 9; i++)
            check("wrap_c3", o_bank[i][3*WIDTH +: WIDTH], 24 + (i % 8));
        cmp_fetches("wrap");

        // Tick 5 cycles after a prior tick
        do_reset(2);
        fire_tick();
        step(4);
        fire_tick();
        step(LAT + 6);
        cmp_fetches("close");
        fire_tick();
        step(LAT + 6);
        cmp_fetches("close_next");

        // Tick during carrier_valid, then one cycle later
        do_reset(2);
        fire_tick();
        step(LAT - 1);
        check("edge_vld_now", carrier_valid, 1'b1);
        fire_tick();
        fire_tick();
        step(LAT + 6);
        cmp_fetches("edge");

        // Reset mid-fetch (previous bank and overrun are nonzero here)
        fire_tick();
        step(5);
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(LAT + 4);
        check("midrst_novld", o_vld_cyc.size(), 0);
        check("midrst_carrier", carrier_out, '0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_overrun", overrun, 1'b0);
        check("midrst_bram_en", bram_en, 1'b0);
        model_reset();
        fire_tick();
        step(LAT + 6);
        cmp_fetches("post_rst");

        // Tick storm then random ticks: many drops
        for (int i = 0; i < 400; i++) fire_tick();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) fire_tick();
            else step(1);
        end
        step(LAT + 6);
`ifdef CARRIER_FETCH_OVR_COUNT_EN
        check("storm_sat", ovr_count, 8'd255);
`endif
        cmp_fetches("storm");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
